// File: rtl/sub_pkg.sv
// Shared types and helpers for the sliced wide subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned SLICE_DEFAULT = 32;

    function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/sub_slice_bin.sv
// Combinational SLICE-bit subtract-with-borrow: {bout, d} = a - b - bin.
module sub_slice_bin #(
    parameter int unsigned SLICE = 32
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    always_comb begin
        {bout, d} = {1'b0, a} - {1'b0, b} - (SLICE + 1)'(bin);
    end

endmodule

// File: rtl/sub_wide_seq.sv
// Multi-cycle WIDTH-bit unsigned subtractor: one SLICE-bit slice per cycle, LSB first,
// borrow chained between slices, valid/ready on both sides.
module sub_wide_seq
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out,
    output logic             busy
);

    localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
    localparam int unsigned CW     = $clog2(NSLICE);

    if ((WIDTH % SLICE) != 0 || NSLICE < 2) begin : g_bad_params
        $error("sub_wide_seq: WIDTH must be a multiple of SLICE with at least two slices");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [SLICE-1:0] slice_d;
    logic             slice_bo;

    sub_slice_bin #(.SLICE(SLICE)) u_slice (
        .a    (a_sh_q[SLICE-1:0]),
        .b    (b_sh_q[SLICE-1:0]),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bo)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> SLICE;
                b_sh_d   = b_sh_q >> SLICE;
                // Slices enter at the MSB end so the first one settles at Diff[SLICE-1:0].
                diff_d   = {slice_d, diff_q[WIDTH-1:SLICE]};
                borrow_d = slice_bo;
                b_out_d  = slice_bo;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(NSLICE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            borrow_q    <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_q      <= '0;
            b_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            borrow_q    <= borrow_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            diff_q      <= diff_d;
            b_out_q     <= b_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Diff      = diff_q;
    assign B_out     = b_out_q;

endmodule

// File: tb/tb_sub_wide_seq.sv
// Scoreboard bench for sub_wide_seq: driver pushes expected results, negedge monitor pops.
module tb_sub_wide_seq;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned SLICE = 32;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bo;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             busy;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_issued = 0;
    int unsigned n_seen = 0;
    bit          rand_ready = 1'b0;

    sub_wide_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (diff),
        .B_out     (b_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output handshake happens at the next rising edge; inputs only move at posedge+1.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got Diff=%h B_out=%b expected no pending result", diff, b_out);
            end else begin
                e = sb.pop_front();
                check("result_diff", diff, e.diff);
                check("result_b_out", {{(WIDTH-1){1'b0}}, b_out}, {{(WIDTH-1){1'b0}}, e.bo});
                n_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [WIDTH-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] ed, input logic eb);
        exp_t e;
        bit   got;
        got = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                e.diff = ed;
                e.bo = eb;
                sb.push_back(e);
                n_issued++;
            end
            tick();
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected an accept within 300 cycles");
        end
        in_valid = 1'b0;
        a = rnd128();
        b = rnd128();
    endtask

    task automatic wait_out_valid();
        int unsigned n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending busy=%b expected 0 pending", sb.size(), busy);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] av, bv, dead;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        dead = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_diff", diff, 0);
        check("rst_b_out", b_out, 0);
        rst = 1'b0;
        tick();

        // 1: wrap-around and exact latency
        out_ready = 1'b1;
        issue(128'd1, 128'd2, {WIDTH{1'b1}}, 1'b1);
        check("lat_ov_at_accept", out_valid, 0);
        check("lat_in_ready_run", in_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("lat_out_valid", out_valid, (i == 4));
        end
        drain(50);

        // 2-3: borrow across a slice, equal operands, edge values
        issue(128'h1_0000_0000, 128'd1, 128'h0_FFFF_FFFF, 1'b0);
        issue(dead, dead, 128'd0, 1'b0);
        issue(128'd0, 128'd0, 128'd0, 1'b0);
        issue(128'd0, 128'd1, {WIDTH{1'b1}}, 1'b1);
        issue({WIDTH{1'b1}}, 128'd0, {WIDTH{1'b1}}, 1'b0);
        issue({1'b1, {(WIDTH-1){1'b0}}}, 128'd1, {1'b0, {(WIDTH-1){1'b1}}}, 1'b0);
        issue(128'h0000_0001_0000_0000_0000_0000_0000_0000, 128'd1,
              128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0);
        drain(100);

        // 4: backpressure with a new request pulsed while busy
        out_ready = 1'b0;
        issue(128'd5, 128'd3, 128'd2, 1'b0);
        wait_out_valid();
        in_valid = 1'b1;
        a = 128'd100;
        b = 128'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_diff", diff, 128'd2);
            check("bp_b_out", b_out, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_after_hs_out_valid", out_valid, 0);
        check("bp_after_hs_in_ready", in_ready, 1);
        tick();
        check("bp_ignored_req_busy", busy, 0);
        check("bp_diff_kept_in_idle", diff, 128'd2);

        // 5: reset at RUN count=2 discards the operation
        issue(128'd9, 128'd4, 128'd5, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_b_out", b_out, 0);
        void'(sb.pop_back());
        n_issued--;
        issue(128'h2_0000_0000_0000_0000, 128'h1, 128'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
        drain(50);

        // 6: random operands with random gaps and backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int unsigned gap, mode;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            mode = $urandom_range(0, 3);
            av = rnd128();
            case (mode)
                0: bv = rnd128();
                1: bv = av;
                2: bv = av + 128'($urandom_range(0, 3)) - 128'd1;
                default: begin
                    av = 128'($urandom);
                    bv = rnd128();
                end
            endcase
            issue(av, bv, av - bv, (av < bv));
        end
        drain(3000);
        check("result_count", n_seen, n_issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
